// File: rtl/bias_bank_if.sv
// +------------------------------------------------------------------+
// | bias_bank_if : bias-bank load port (start/bank, valid/ready data, |
// |                load status).       Rev 1.0                        |
// +------------------------------------------------------------------+
`default_nettype none

interface bias_bank_if #(
    parameter int WIDTH   = 32,
    parameter int N_BANKS = 4
);
    localparam int BANK_W = $clog2(N_BANKS);

    logic              ld_start;
    logic [BANK_W-1:0] ld_bank;
    logic              wr_valid;
    logic              wr_ready;
    logic [WIDTH-1:0]  wr_data;
    logic              ld_busy;
    logic              ld_done;
    logic              ld_err;

    modport master (
        output ld_start, ld_bank, wr_valid, wr_data,
        input  wr_ready, ld_busy, ld_done, ld_err
    );

    modport slave (
        input  ld_start, ld_bank, wr_valid, wr_data,
        output wr_ready, ld_busy, ld_done, ld_err
    );
endinterface

`default_nettype wire

// File: rtl/bias_bank.sv
// +------------------------------------------------------------------+
// | bias_bank : multi-bank runtime-loadable bias store with streaming |
// |             loader and per-group registered bias buses.           |
// |             Optional macro BIAS_CLAMP_EN saturates loaded words.  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module bias_bank #(
    parameter int               WIDTH    = 32,
    parameter int               N_G_L2   = 3,
    parameter int               N_G_L3   = 9,
    parameter int               N_D_L2   = 3,
    parameter int               N_D_L3   = 1,
    parameter int               N_BANKS  = 4,
    parameter logic [WIDTH-1:0] BIAS_MAX = 32'h04000000,
    localparam int              BANK_W   = $clog2(N_BANKS),
    localparam int              TOTAL    = N_G_L2 + N_G_L3 + N_D_L2 + N_D_L3
) (
    input  wire logic                     clk,
    input  wire logic                     rst_n,
    input  wire logic [4*BANK_W-1:0]      sel,
    bias_bank_if.slave                    ld,
    output logic      [N_G_L2*WIDTH-1:0]  bg2,
    output logic      [N_G_L3*WIDTH-1:0]  bg3,
    output logic      [N_D_L2*WIDTH-1:0]  bd2,
    output logic      [N_D_L3*WIDTH-1:0]  bd3,
    output logic      [3:0]               out_valid
);

    localparam int              CNT_W     = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam logic [BANK_W:0] c_n_banks = (BANK_W+1)'(N_BANKS);
    localparam int              c_off_g3  = N_G_L2;
    localparam int              c_off_d2  = N_G_L2 + N_G_L3;
    localparam int              c_off_d3  = N_G_L2 + N_G_L3 + N_D_L2;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [BANK_W-1:0]  r_ld_bank;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_mem [N_BANKS][TOTAL];
    logic [N_BANKS-1:0] r_loaded;
    logic [WIDTH-1:0]   r_bus [TOTAL];
    logic [3:0]         r_out_valid;

    logic               w_bank_ok;
    logic               w_start_ok;
    logic               w_beat;
    logic               w_last;
    logic [WIDTH-1:0]   w_wr_word;
    logic [BANK_W-1:0]  w_sel    [4];
    logic [3:0]         w_sel_ok;
    logic [3:0]         w_hold;
    logic [WIDTH-1:0]   w_rd     [TOTAL];

    // Word index within a bank -> owning bias group (0=bg2,1=bg3,2=bd2,3=bd3)
    function automatic logic [1:0] grp_of(input int k);
        if (k < c_off_g3)      return 2'd0;
        else if (k < c_off_d2) return 2'd1;
        else if (k < c_off_d3) return 2'd2;
        else                   return 2'd3;
    endfunction

    assign w_bank_ok  = ({1'b0, ld.ld_bank} < c_n_banks);
    assign w_start_ok = ld.ld_start && (r_state == S_IDLE) && w_bank_ok;
    assign w_beat     = (r_state == S_LOAD) && ld.wr_valid;
    assign w_last     = w_beat && (r_cnt == CNT_W'(TOTAL - 1));

`ifdef BIAS_CLAMP_EN
    always_comb begin
        w_wr_word = ld.wr_data;
        if ($signed(ld.wr_data) > $signed(BIAS_MAX))
            w_wr_word = BIAS_MAX;
        else if ($signed(ld.wr_data) < -$signed(BIAS_MAX))
            w_wr_word = -BIAS_MAX;
    end
`else
    logic w_unused_bias_max;
    assign w_unused_bias_max = ^BIAS_MAX;
    assign w_wr_word         = ld.wr_data;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        ld.wr_ready = 1'b0;
        ld.ld_busy  = 1'b0;
        ld.ld_done  = 1'b0;
        ld.ld_err   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                ld.wr_ready = 1'b1;
                ld.ld_busy  = 1'b1;
                if (w_last) w_state_nxt = S_COMMIT;
            end
            S_COMMIT: begin
                ld.ld_busy  = 1'b1;
                ld.ld_done  = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        ld.ld_err = rst_n && ld.ld_start && ((r_state != S_IDLE) || !w_bank_ok);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ld_bank <= '0;
            r_cnt     <= '0;
            r_loaded  <= '0;
            for (int b = 0; b < N_BANKS; b++)
                for (int w = 0; w < TOTAL; w++)
                    r_mem[b][w] <= '0;
        end else begin
            if (w_start_ok) begin
                r_ld_bank <= ld.ld_bank;
                r_cnt     <= '0;
            end
            if (w_beat) begin
                r_mem[r_ld_bank][r_cnt] <= w_wr_word;
                r_cnt                   <= r_cnt + 1'b1;
            end
            if (r_state == S_COMMIT) r_loaded[r_ld_bank] <= 1'b1;
        end
    end

    // A group looking at the bank under load freezes so partial data never leaks out
    always_comb begin
        w_sel_ok = '0;
        w_hold   = '0;
        for (int g = 0; g < 4; g++) begin
            w_sel[g]    = sel[g*BANK_W +: BANK_W];
            w_sel_ok[g] = ({1'b0, w_sel[g]} < c_n_banks);
            w_hold[g]   = (r_state != S_IDLE) && (w_sel[g] == r_ld_bank);
        end
        for (int k = 0; k < TOTAL; k++) begin
            w_rd[k] = '0;
            if (w_sel_ok[grp_of(k)]) w_rd[k] = r_mem[w_sel[grp_of(k)]][k];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= '0;
            for (int k = 0; k < TOTAL; k++) r_bus[k] <= '0;
        end else begin
            for (int k = 0; k < TOTAL; k++)
                if (!w_hold[grp_of(k)]) r_bus[k] <= w_rd[k];
            for (int g = 0; g < 4; g++)
                if (!w_hold[g]) r_out_valid[g] <= w_sel_ok[g] && r_loaded[w_sel[g]];
        end
    end

    always_comb begin
        bg2 = '0;
        bg3 = '0;
        bd2 = '0;
        bd3 = '0;
        for (int i = 0; i < N_G_L2; i++) bg2[i*WIDTH +: WIDTH] = r_bus[i];
        for (int i = 0; i < N_G_L3; i++) bg3[i*WIDTH +: WIDTH] = r_bus[c_off_g3 + i];
        for (int i = 0; i < N_D_L2; i++) bd2[i*WIDTH +: WIDTH] = r_bus[c_off_d2 + i];
        for (int i = 0; i < N_D_L3; i++) bd3[i*WIDTH +: WIDTH] = r_bus[c_off_d3 + i];
    end

    assign out_valid = r_out_valid;

endmodule

`default_nettype wire

// File: tb/tb_bias_bank.sv
// +------------------------------------------------------------------+
// | tb_bias_bank : directed self-checking bench for bias_bank         |
// |                (3-bank build so an out-of-range bank is drivable).|
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module tb_bias_bank;
    localparam int W  = 32;
    localparam int NB = 3;
    localparam int BW = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [4*BW-1:0]  sel;
    logic [3*W-1:0]   bg2;
    logic [9*W-1:0]   bg3;
    logic [3*W-1:0]   bd2;
    logic [W-1:0]     bd3;
    logic [3:0]       out_valid;

    int n_tests = 0;
    int n_fail  = 0;

    bias_bank_if #(.WIDTH(W), .N_BANKS(NB)) ld();

    bias_bank #(.WIDTH(W), .N_BANKS(NB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sel       (sel),
        .ld        (ld),
        .bg2       (bg2),
        .bg3       (bg3),
        .bd2       (bd2),
        .bd3       (bd3),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input logic [BW-1:0] bank);
        ld.ld_start = 1'b1;
        ld.ld_bank  = bank;
        step();
        ld.ld_start = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] d);
        int n = 0;
        ld.wr_valid = 1'b1;
        ld.wr_data  = d;
        #1;
        while (ld.wr_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) chk("beat_timeout", 32'(ld.wr_ready), 32'd1);
        step();
        ld.wr_valid = 1'b0;
        ld.wr_data  = 32'hDEADBEEF;
    endtask

    task automatic stall();
        ld.wr_valid = 1'b0;
        ld.wr_data  = 32'hBADC0FFE;
        step();
    endtask

    initial begin
        logic [31:0] exp_hi, exp_lo;
        rst_n       = 1'b0;
        sel         = '0;
        ld.ld_start = 1'b0;
        ld.ld_bank  = '0;
        ld.wr_valid = 1'b0;
        ld.wr_data  = '0;
        step();
        step();
        chk("rst_bg2",   bg2[0 +: W], 32'd0);
        chk("rst_bd3",   bd3, 32'd0);
        chk("rst_ov",    32'(out_valid), 32'd0);
        chk("rst_rdy",   32'(ld.wr_ready), 32'd0);
        chk("rst_busy",  32'(ld.ld_busy), 32'd0);
        chk("rst_done",  32'(ld.ld_done), 32'd0);
        chk("rst_err",   32'(ld.ld_err), 32'd0);
        rst_n = 1'b1;
        step();
        chk("idle_ov",   32'(out_valid), 32'd0);
        chk("idle_bg3",  bg3[8*W +: W], 32'd0);

        // Bank 0, back-to-back beats, all groups watching bank 0
        start_load(2'd0);
        chk("ld0_rdy",  32'(ld.wr_ready), 32'd1);
        chk("ld0_busy", 32'(ld.ld_busy), 32'd1);
        for (int k = 0; k < 16; k++) begin
            if (k == 8) chk("ld0_hold_bg2", bg2[0 +: W], 32'd0);
            send_beat(32'h01000000 + k);
        end
        chk("ld0_done",        32'(ld.ld_done), 32'd1);
        chk("ld0_rdy_commit",  32'(ld.wr_ready), 32'd0);
        step();
        chk("ld0_done_pulse",  32'(ld.ld_done), 32'd0);
        chk("ld0_idle",        32'(ld.ld_busy), 32'd0);
        chk("ld0_hold_commit", bg2[0 +: W], 32'd0);
        step();
        chk("ld0_bg2_0", bg2[0 +: W],   32'h01000000);
        chk("ld0_bg2_2", bg2[2*W +: W], 32'h01000002);
        chk("ld0_bg3_8", bg3[8*W +: W], 32'h0100000B);
        chk("ld0_bd2_0", bd2[0 +: W],   32'h0100000C);
        chk("ld0_bd3",   bd3,           32'h0100000F);
        chk("ld0_ov",    32'(out_valid), 32'hF);

        // Bank 1 with stalls; bg3 watches bank 1, others bank 0
        sel = {2'd0, 2'd0, 2'd1, 2'd0};
        step();
        chk("pre1_bg3", bg3[0 +: W], 32'd0);
        chk("pre1_ov",  32'(out_valid), 32'b1101);
        start_load(2'd1);
        for (int k = 0; k < 16; k++) begin
            if (k == 15) chk("ld1_prelast_rdy", 32'(ld.wr_ready), 32'd1);
            send_beat(32'h02000000 + k);
            if (k == 4) begin
                chk("ld1_hold_bg3", bg3[0 +: W], 32'd0);
                chk("ld1_hold_ov",  32'(out_valid), 32'b1101);
            end
            if (k == 5) begin
                ld.ld_start = 1'b1;
                ld.ld_bank  = 2'd2;
                #1;
                chk("err_in_load", 32'(ld.ld_err), 32'd1);
                stall();
                ld.ld_start = 1'b0;
                #1;
                chk("err_pulse_end", 32'(ld.ld_err), 32'd0);
                chk("err_load_kept", 32'(ld.ld_busy), 32'd1);
            end
            if (k == 7) begin
                sel[1:0] = 2'd2;
                stall();
                chk("ld1_bg2_follow2", bg2[0 +: W], 32'd0);
                chk("ld1_ov_follow2",  32'(out_valid[0]), 32'd0);
                sel[1:0] = 2'd0;
                stall();
                chk("ld1_bg2_follow0", bg2[0 +: W], 32'h01000000);
            end
            if (k < 15) stall();
        end
        chk("ld1_done", 32'(ld.ld_done), 32'd1);
        step();
        chk("ld1_hold_commit", bg3[0 +: W], 32'd0);
        step();
        chk("ld1_bg3_0", bg3[0 +: W],   32'h02000003);
        chk("ld1_bg3_8", bg3[8*W +: W], 32'h0200000B);
        chk("ld1_bg2_0", bg2[0 +: W],   32'h01000000);
        chk("ld1_ov",    32'(out_valid), 32'hF);

        // Out-of-range bank request in IDLE
        ld.ld_start = 1'b1;
        ld.ld_bank  = 2'd3;
        #1;
        chk("err_oor", 32'(ld.ld_err), 32'd1);
        step();
        ld.ld_start = 1'b0;
        #1;
        chk("err_oor_idle", 32'(ld.ld_busy), 32'd0);
        chk("err_oor_end",  32'(ld.ld_err), 32'd0);

        // Select latency on bd2: bank 0 -> bank 1
        sel[5:4] = 2'd1;
        #1;
        chk("sel_lat_before", bd2[0 +: W], 32'h0100000C);
        step();
        chk("sel_lat_after0", bd2[0 +: W],   32'h0200000C);
        chk("sel_lat_after2", bd2[2*W +: W], 32'h0200000E);

        // Reset in the middle of a load of bank 2
        sel = '0;
        start_load(2'd2);
        for (int k = 0; k < 7; k++) send_beat(32'h0A000000 + k);
        rst_n = 1'b0;
        step();
        chk("mrst_bg2",  bg2[0 +: W], 32'd0);
        chk("mrst_bg3",  bg3[8*W +: W], 32'd0);
        chk("mrst_bd2",  bd2[0 +: W], 32'd0);
        chk("mrst_bd3",  bd3, 32'd0);
        chk("mrst_ov",   32'(out_valid), 32'd0);
        chk("mrst_rdy",  32'(ld.wr_ready), 32'd0);
        chk("mrst_busy", 32'(ld.ld_busy), 32'd0);
        chk("mrst_done", 32'(ld.ld_done), 32'd0);
        rst_n = 1'b1;
        step();
        chk("mrst_bank0_clr", bg2[0 +: W], 32'd0);
        chk("mrst_loaded_clr", 32'(out_valid), 32'd0);

        // Fresh full load of bank 2 with extreme words; start during COMMIT rejected
        sel = {2'd2, 2'd2, 2'd2, 2'd2};
        start_load(2'd2);
        for (int k = 0; k < 16; k++) begin
            if (k == 0)      send_beat(32'h7FFFFFFF);
            else if (k == 1) send_beat(32'h80000000);
            else             send_beat(32'h03000000 + k);
        end
        chk("ld2_done", 32'(ld.ld_done), 32'd1);
        ld.ld_start = 1'b1;
        ld.ld_bank  = 2'd0;
        #1;
        chk("err_commit", 32'(ld.ld_err), 32'd1);
        step();
        ld.ld_start = 1'b0;
        #1;
        chk("err_commit_idle", 32'(ld.ld_busy), 32'd0);
        step();
`ifdef BIAS_CLAMP_EN
        exp_hi = 32'h04000000;
        exp_lo = 32'hFC000000;
`else
        exp_hi = 32'h7FFFFFFF;
        exp_lo = 32'h80000000;
`endif
        chk("ld2_word_hi", bg2[0 +: W],   exp_hi);
        chk("ld2_word_lo", bg2[1*W +: W], exp_lo);
        chk("ld2_bg3_0",   bg3[0 +: W],   32'h03000003);
        chk("ld2_bd3",     bd3,           32'h0300000F);
        chk("ld2_ov",      32'(out_valid), 32'hF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/bias_bank.md
# bias_bank

Writable, multi-bank bias store for the GAN generator/discriminator datapath. It replaces fixed bias constants with `N_BANKS` runtime-loadable bias sets per network. A streaming load FSM fills one bank at a time through a valid/ready port. Each of the four bias groups (bg2, bg3, bd2, bd3) independently selects its bank and drives a registered, packed bias bus into the layer MAC units.

## Interface
- `WIDTH`, 32: bias word width, signed Q7.24 (0x01000000 = 1.0).
- `N_G_L2`, 3: generator layer-2 bias count.
- `N_G_L3`, 9: generator layer-3 bias count.
- `N_D_L2`, 3: discriminator layer-2 bias count.
- `N_D_L3`, 1: discriminator layer-3 bias count.
- `N_BANKS`, 4: bias sets stored. Must be ≥2. `BANK_W = $clog2(N_BANKS)` (localparam).
- `BIAS_MAX`, 32'h04000000: clamp magnitude (+4.0). Used only with `BIAS_CLAMP_EN`.
- `TOTAL` (localparam) = `N_G_L2+N_G_L3+N_D_L2+N_D_L3` (16 by default).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `sel` in 4*BANK_W: per-group bank select. Slice 0 = bg2, 1 = bg3, 2 = bd2, 3 = bd3.
- `ld_start` in 1: begin loading bank `ld_bank`.
- `ld_bank` in BANK_W: target bank, sampled with `ld_start`.
- `wr_valid` in 1, `wr_ready` out 1, `wr_data` in WIDTH: load stream.
- `ld_busy` out 1: high in LOAD and COMMIT.
- `ld_done` out 1: one-cycle pulse on commit.
- `ld_err` out 1: one-cycle pulse on a rejected `ld_start`.
- `bg2` out N_G_L2*WIDTH, `bg3` out N_G_L3*WIDTH, `bd2` out N_D_L2*WIDTH, `bd3` out N_D_L3*WIDTH: registered bias buses. Element i is at `[i*WIDTH +: WIDTH]`.
- `out_valid` out 4: bit g high when group g's displayed bank has been committed at least once.

## Operation
- Storage is `N_BANKS` × `TOTAL` words. Address map within a bank: 0..2 → bg2, 3..11 → bg3, 12..14 → bd2, 15 → bd3 (defaults; offsets follow the parameters).
- FSM states: IDLE, LOAD, COMMIT.
  - IDLE → LOAD on `ld_start` with `ld_bank < N_BANKS`. Latches the bank and clears the word counter.
  - LOAD: `wr_ready`=1. Each `wr_valid && wr_ready` writes `wr_data` to `bank[ld_bank][cnt]` and increments `cnt`. The beat with `cnt == TOTAL-1` moves the FSM to COMMIT.
  - COMMIT (one cycle): sets `loaded[ld_bank]`, pulses `ld_done`, and returns to IDLE. `wr_ready`=0.
- `ld_err` pulses, with no state change, when `ld_start` arrives in LOAD or COMMIT, or when `ld_bank >= N_BANKS`.
- Output refresh: each cycle, group g's bus register loads the words of `bank[sel_g]`, and `out_valid[g]` loads `loaded[sel_g]`.
  - Exception: in LOAD and COMMIT, a group whose `sel_g == ld_bank` holds its bus and `out_valid` bit. A partially loaded bank is never visible.
  - Other groups keep refreshing during a load.
- Two or more groups may select the same bank.
- Loading a previously committed bank overwrites it. After COMMIT, the new contents appear on the next refresh.

## Timing
- Select-to-output latency: 1 cycle. A `sel` change at edge n is visible on the buses after edge n+1.
- Load: `ld_start` at edge n gives `wr_ready`=1 from cycle n+1. With back-to-back beats, the last beat is accepted at edge n+TOTAL and `ld_done` is high in cycle n+TOTAL+1. Buses of groups selecting that bank show the new data after edge n+TOTAL+2.
- Stalls (`wr_valid`=0) are allowed anywhere in LOAD. The counter holds.
- `ld_start` in the same cycle as the ending COMMIT is rejected (`ld_err`).
- Reset, including mid-load: FSM→IDLE, `cnt`=0, all bank words=0, `loaded`=0. All bias buses=0, `out_valid`=0, `wr_ready`=0, `ld_busy`=0, `ld_done`=0, `ld_err`=0. Data from an interrupted load is discarded.

## Configuration
- `BIAS_CLAMP_EN` defined: each accepted `wr_data` is saturated to [−BIAS_MAX, +BIAS_MAX] (signed compare) before storage.
- `BIAS_CLAMP_EN` undefined: `wr_data` is stored unmodified and `BIAS_MAX` is unused.

## Test plan
- Reset, then `sel`=0 for all groups → all buses 0 and `out_valid`=4'b0000. Load bank 0 with words 0x01000000+k (k=0..15) → `ld_done` one cycle after the 16th beat. Then `bg2[0]`=0x01000000, `bg3[8]`=0x0100000B, `bd3`=0x0100000F, `out_valid`=4'b1111.
- Load bank 1 with `wr_valid` toggled every other cycle while bg3 selects bank 1 and bg2 selects bank 0 → bg3 holds its old value until after COMMIT. bg2 follows its `sel` throughout. Exactly 16 beats are accepted.
- `ld_start` during LOAD and `ld_start` with bank=N_BANKS → single-cycle `ld_err`, load in progress unaffected.
- Assert `rst_n`=0 after 7 beats of a load → next cycle all outputs 0, FSM idle, `loaded`=0. A fresh full load then completes normally.
- With `BIAS_CLAMP_EN`, write 0x7FFFFFFF and 0x80000000 → stored as 0x04000000 and 0xFC000000. Without the macro, the values are stored unchanged.
- Select change from bank 0 to bank 1 at edge n on bd2 → bd2 shows bank-1 words after edge n+1.
